// File: rtl/pc_ctrl.sv
// Program counter controller: sequential fetch, branch redirect, stall,
// and a two-state exception level with exception entry / return.
module pc_ctrl #(
    parameter int unsigned             WIDTH      = 32,
    parameter logic [WIDTH-1:0]        RESET_VEC  = 'h0000_3000,
    parameter logic [WIDTH-1:0]        EXC_VEC    = 'h0000_4180,
    parameter int unsigned             STEP       = 4,
    parameter int unsigned             ALIGN_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             exc_req,
    input  logic [WIDTH-1:0] exc_pc,
    input  logic             eret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic [WIDTH-1:0] epc,
    output logic             exl,
    output logic             misaligned
);

    typedef enum logic {
        NORM = 1'b0,
        EXC  = 1'b1
    } state_t;

    // Initialisers give the reset values at power-up, before any reset edge.
    state_t           r_state = NORM;
    logic [WIDTH-1:0] r_pc    = RESET_VEC;
    logic [WIDTH-1:0] r_epc   = '0;
    logic [WIDTH-1:0] w_pc_plus;

    assign w_pc_plus  = r_pc + WIDTH'(STEP);
    assign pc         = r_pc;
    assign pc_plus    = w_pc_plus;
    assign epc        = r_epc;
    assign exl        = (r_state == EXC);
    assign misaligned = |r_pc[ALIGN_BITS-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= RESET_VEC;
            r_epc   <= '0;
            r_state <= NORM;
        end else if (exc_req) begin
            // Nested exceptions keep the original return address.
            r_pc    <= EXC_VEC;
            r_state <= EXC;
            if (r_state == NORM) begin
                r_epc <= exc_pc;
            end
        end else if (eret && (r_state == EXC)) begin
            r_pc    <= r_epc;
            r_state <= NORM;
        end else if (stall) begin
            r_pc    <= r_pc;
        end else if (br_taken) begin
            r_pc    <= br_target;
        end else begin
            r_pc    <= w_pc_plus;
        end
    end

endmodule
